// File: rtl/brightness_pe_array.sv
// Brightness PE array: snapshots a diagonal-skewed 7x4 tile, saturates pixel+offset in 4 lane PEs, writes the 4x4 result row-major.
// Latency: start accepted at edge 0, writes in cycles 9-24, done pulse in cycle 25.
// Backpressure: none; start is ignored unless idle and every RAM write is assumed to land.
module brightness_pe_array #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int OFFSET_WIDTH = 9,
    parameter int PIXEL_MAX    = 255,
    parameter int BASE_ADDR    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic signed [OFFSET_WIDTH-1:0] brightness,
    input  logic [DATA_WIDTH-1:0]          tpu_data_arr [0:6][0:3],
    output logic                           wr_en,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           busy,
    output logic                           done
);
    localparam int SUM_WIDTH = DATA_WIDTH + 2;
    localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = SUM_WIDTH'(PIXEL_MAX);
    localparam logic [DATA_WIDTH-1:0] PIX_MAX = DATA_WIDTH'(PIXEL_MAX);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, WRITE, DONE} state_t;

    state_t                         state, state_nxt;
    logic [2:0]                     diag_cnt;
    logic [3:0]                     wr_idx;
    logic [DATA_WIDTH-1:0]          tile_snap [0:6][0:3];
    logic signed [OFFSET_WIDTH-1:0] offset_snap;
    logic [3:0]                     lane_vld;
    logic [1:0]                     lane_col [0:3];
    logic [3:0]                     pe_vld;
    logic [1:0]                     pe_col [0:3];
    logic [DATA_WIDTH-1:0]          pe_dat [0:3];
    logic [DATA_WIDTH-1:0]          result [0:3][0:3];

    function automatic logic [DATA_WIDTH-1:0] pe_sat(input logic [DATA_WIDTH-1:0] pix,
                                                     input logic signed [OFFSET_WIDTH-1:0] off);
        logic signed [SUM_WIDTH-1:0] sum;
        sum = $signed({2'b00, pix}) + $signed({{(SUM_WIDTH-OFFSET_WIDTH){off[OFFSET_WIDTH-1]}}, off});
        if (sum[SUM_WIDTH-1]) return '0;
        if (sum > SUM_MAX) return PIX_MAX;
        return sum[DATA_WIDTH-1:0];
    endfunction

    // Lane i carries pixel (row i, col d-i); slots outside the 4x4 tile are dropped.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_col[i] = 2'(diag_cnt - 3'(i));
            lane_vld[i] = (state == FEED) && (3'(i) <= diag_cnt) && ((diag_cnt - 3'(i)) <= 3'd3);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FEED;
            FEED:    if (diag_cnt == 3'd6) state_nxt = DRAIN;
            DRAIN:   state_nxt = WRITE;
            WRITE:   if (wr_idx == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            diag_cnt    <= '0;
            wr_idx      <= '0;
            offset_snap <= '0;
            pe_vld      <= '0;
            for (int d = 0; d < 7; d++)
                for (int i = 0; i < 4; i++)
                    tile_snap[d][i] <= '0;
            for (int r = 0; r < 4; r++) begin
                pe_col[r] <= '0;
                pe_dat[r] <= '0;
                for (int c = 0; c < 4; c++)
                    result[r][c] <= '0;
            end
        end else begin
            state    <= state_nxt;
            diag_cnt <= (state == FEED && diag_cnt != 3'd6) ? diag_cnt + 3'd1 : '0;
            wr_idx   <= (state == WRITE) ? wr_idx + 4'd1 : '0;
            if (state == IDLE && start) begin
                offset_snap <= brightness;
                tile_snap   <= tpu_data_arr;
            end
            // PE stage registers one diagonal; the capture stage lands it in the matrix an edge later.
            for (int i = 0; i < 4; i++) begin
                pe_vld[i] <= lane_vld[i];
                pe_col[i] <= lane_col[i];
                pe_dat[i] <= lane_vld[i] ? pe_sat(tile_snap[diag_cnt][i], offset_snap) : '0;
                if (pe_vld[i])
                    result[i][pe_col[i]] <= pe_dat[i];
            end
        end
    end

    assign wr_en   = (state == WRITE);
    assign wr_addr = wr_en ? BASE + ADDR_WIDTH'(wr_idx) : '0;
    assign wr_data = wr_en ? result[wr_idx[3:2]][wr_idx[1:0]] : '0;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
endmodule
